intersection_phase_scheduler: RTL and testbench

Sequences the intersection signal heads: latches pedestrian and vehicle demand, arbitrates round-robin between conflicting phases, and drives the green/yellow/clearance outputs through timed GREEN -> YELLOW -> ALL_RED intervals. Up and down are compatible and may be green together; turn and pedestrian are exclusive with everything else. It sits directly above the intersection signal outputs (pedestrian_green, up_green, down_green, turn_green), which the existing cover/safety checkers observe.

---
 rtl/intersection_phase_scheduler_pkg.sv | 23 ++
 rtl/intersection_phase_scheduler_if.sv | 35 +++
 rtl/intersection_phase_scheduler_arbiter.sv | 43 ++++
 rtl/intersection_phase_scheduler.sv | 118 +++++++++++
 tb/tb_intersection_phase_scheduler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/intersection_phase_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intersection_phase_scheduler_pkg : shared states, phase indices, compat mask
// Rev 1.0
// ----------------------------------------------------------------------------
package intersection_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  localparam int PH_PED  = 0;
  localparam int PH_UP   = 1;
  localparam int PH_DOWN = 2;
  localparam int PH_TURN = 3;

  // Row p lists the phases that may share green with phase p (only UP<->DOWN).
  localparam logic [3:0][3:0] COMPAT = {4'b0000, 4'b0010, 4'b0100, 4'b0000};

endpackage
`default_nettype wire

// File: rtl/intersection_phase_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intersection_phase_scheduler_if : request inputs and signal-head outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface intersection_phase_scheduler_if;

  logic       ped_req;
  logic       up_req;
  logic       down_req;
  logic       turn_req;
  logic       pedestrian_green;
  logic       pedestrian_flash;
  logic       up_green;
  logic       up_yellow;
  logic       down_green;
  logic       down_yellow;
  logic       turn_green;
  logic       turn_yellow;
  logic [3:0] active_phase;

  modport master (
    output ped_req, up_req, down_req, turn_req,
    input  pedestrian_green, pedestrian_flash, up_green, up_yellow,
           down_green, down_yellow, turn_green, turn_yellow, active_phase
  );

  modport slave (
    input  ped_req, up_req, down_req, turn_req,
    output pedestrian_green, pedestrian_flash, up_green, up_yellow,
           down_green, down_yellow, turn_green, turn_yellow, active_phase
  );

endinterface
`default_nettype wire

// File: rtl/intersection_phase_scheduler_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intersection_phase_scheduler_arbiter : round-robin phase selection
// Rev 1.0
// ----------------------------------------------------------------------------
module intersection_phase_scheduler_arbiter
  import intersection_phase_scheduler_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] pointer,
  output logic [3:0] served,
  output logic [1:0] next_pointer
);

  logic [1:0] winner;
  logic [1:0] idx;
  logic [1:0] top;
  logic       found;

  always_comb begin
    winner = pointer;
    idx    = pointer;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = pointer + 2'(i);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end

    // A compatible partner rides along only if it is already pending.
    served = found ? ((4'b0001 << winner) | (COMPAT[winner] & pending)) : 4'b0000;

    top = winner;
    for (int i = 0; i < 4; i++) begin
      if (served[i]) top = 2'(i);
    end
    next_pointer = found ? top + 2'd1 : pointer;
  end

endmodule
`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intersection_phase_scheduler : demand latch + GREEN/YELLOW/ALL_RED sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int CLEAR_TIME  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  intersection_phase_scheduler_if.slave sig
);

  localparam int            CW          = $clog2(MAX_GREEN + 1);
  localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST    = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_TIME - 1);

  state_t        state, state_next;
  logic [CW-1:0] timer, timer_next;
  logic [3:0]    pending, pending_next;
  logic [3:0]    served, served_next;
  logic [1:0]    pointer, pointer_next;
  logic [3:0]    arb_served;
  logic [1:0]    arb_pointer;
  logic [3:0]    req;
  logic          competing;
  logic          gap;
  logic [3:0]    green_out, yellow_out, active_out;

  assign req = {sig.turn_req, sig.down_req, sig.up_req, sig.ped_req};

  intersection_phase_scheduler_arbiter u_arbiter (
    .pending      (pending),
    .pointer      (pointer),
    .served       (arb_served),
    .next_pointer (arb_pointer)
  );

  always_comb begin
    state_next   = state;
    served_next  = served;
    pointer_next = pointer;
    pending_next = pending | req;
    competing    = |(pending & ~served);
    gap          = (req & served) == 4'b0000;

    case (state)
      ALL_RED: begin
        if (timer >= CLEAR_LAST && |pending) begin
          state_next   = GREEN;
          served_next  = arb_served;
          pointer_next = arb_pointer;
        end
      end
      GREEN: begin
        pending_next = (pending | req) & ~served;
        if (competing && (timer == MAX_LAST || (timer >= MIN_LAST && gap)))
          state_next = YELLOW;
      end
      YELLOW: begin
        if (timer == YELLOW_LAST) state_next = ALL_RED;
      end
      default: state_next = ALL_RED;
    endcase

    if (state_next == GREEN && state != GREEN)
      pending_next = (pending | req) & ~served_next;

    // Timer restarts on every entry and saturates while resting in red or green.
    if (state_next != state)
      timer_next = '0;
    else if ((state == ALL_RED && timer >= CLEAR_LAST) || (state == GREEN && timer >= MAX_LAST))
      timer_next = timer;
    else
      timer_next = timer + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ALL_RED;
      timer      <= '0;
      pending    <= '0;
      served     <= '0;
      pointer    <= 2'(PH_PED);
      green_out  <= '0;
      yellow_out <= '0;
      active_out <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      pending    <= pending_next;
      served     <= served_next;
      pointer    <= pointer_next;
      green_out  <= (state_next == GREEN)   ? served_next : 4'b0000;
      yellow_out <= (state_next == YELLOW)  ? served_next : 4'b0000;
      active_out <= (state_next == ALL_RED) ? 4'b0000 : served_next;
    end
  end

  assign sig.pedestrian_green = green_out[PH_PED];
  assign sig.pedestrian_flash = yellow_out[PH_PED];
  assign sig.up_green         = green_out[PH_UP];
  assign sig.up_yellow        = yellow_out[PH_UP];
  assign sig.down_green       = green_out[PH_DOWN];
  assign sig.down_yellow      = yellow_out[PH_DOWN];
  assign sig.turn_green       = green_out[PH_TURN];
  assign sig.turn_yellow      = yellow_out[PH_TURN];
  assign sig.active_phase     = active_out;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_intersection_phase_scheduler : directed segment table plus random stress
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

  // {ped_g, ped_flash, up_g, up_y, down_g, down_y, turn_g, turn_y, active[3:0]}
  localparam logic [11:0] RED = 12'h000;
  localparam logic [11:0] PG  = {8'b1000_0000, 4'b0001};
  localparam logic [11:0] PF  = {8'b0100_0000, 4'b0001};
  localparam logic [11:0] UG  = {8'b0010_0000, 4'b0010};
  localparam logic [11:0] UY  = {8'b0001_0000, 4'b0010};
  localparam logic [11:0] DG  = {8'b0000_1000, 4'b0100};
  localparam logic [11:0] UDG = {8'b0010_1000, 4'b0110};
  localparam logic [11:0] UDY = {8'b0001_0100, 4'b0110};
  localparam logic [11:0] TG  = {8'b0000_0010, 4'b1000};
  localparam logic [11:0] TY  = {8'b0000_0001, 4'b1000};

  typedef struct {
    logic        do_reset;
    logic [3:0]  req;       // {turn, down, up, ped}
    logic [11:0] exp;
    int          n;
  } seg_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  seg_t tbl[$];

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler dut (
    .clock (clock),
    .reset (reset),
    .sig   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] obs();
    return {bus.pedestrian_green, bus.pedestrian_flash, bus.up_green, bus.up_yellow,
            bus.down_green, bus.down_yellow, bus.turn_green, bus.turn_yellow, bus.active_phase};
  endfunction

  task automatic set_req(input logic [3:0] r);
    bus.ped_req  = r[0];
    bus.up_req   = r[1];
    bus.down_req = r[2];
    bus.turn_req = r[3];
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reset lands between edges so the outputs must clear without a clock.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    set_req(4'b0000);
    #1 chk("async_reset", obs(), RED);
    repeat (2) begin
      @(negedge clock);
      chk("held_reset", obs(), RED);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [11:0] e, input int n);
    tbl.push_back('{1'b0, r, e, n});
  endtask

  task automatic add_reset();
    tbl.push_back('{1'b1, 4'b0000, RED, 0});
  endtask

  logic [3:0] g, y, g_prev, veh_req;
  logic [3:0] r;
  logic       waiting [4];
  int         wait_cnt [4];
  int         red_run;
  logic       starve;

  initial begin
    set_req(4'b0000);

    // Idle: rests in red with no demand.
    add_reset(); add(4'b0000, RED, 30);
    // All four at once: PED, then UP+DOWN together, then TURN.
    add_reset();
    add(4'b1111, RED, 1); add(4'b0000, RED, 1);
    add(4'b0000, PG, 4);  add(4'b0000, PF, 3);  add(4'b0000, RED, 2);
    add(4'b0000, UDG, 4); add(4'b0000, UDY, 3); add(4'b0000, RED, 2);
    add(4'b0000, TG, 6);
    // Up pulse rests in green; a later down request ends it at once.
    add_reset();
    add(4'b0010, RED, 1); add(4'b0000, RED, 1);
    add(4'b0000, UG, 22); add(4'b0100, UG, 2);
    add(4'b0100, UY, 3);  add(4'b0100, RED, 2); add(4'b0100, DG, 5);
    // Up held: max-out at 10 cycles, turn served, then up again.
    add_reset();
    add(4'b0010, RED, 2); add(4'b1010, UG, 1); add(4'b0010, UG, 9);
    add(4'b0010, UY, 3);  add(4'b0010, RED, 2);
    add(4'b0010, TG, 4);  add(4'b0010, TY, 3);  add(4'b0010, RED, 2);
    add(4'b0010, UG, 3);
    // Up dropped early with turn waiting: gap-out at min green.
    add_reset();
    add(4'b1010, RED, 2); add(4'b1010, UG, 1); add(4'b0000, UG, 3);
    add(4'b0000, UY, 3);  add(4'b0000, RED, 2); add(4'b0000, TG, 3);
    // Reset during green, then a full red interval on restart.
    add_reset();
    add(4'b0010, RED, 1); add(4'b0000, RED, 1); add(4'b0000, UG, 2);

    foreach (tbl[k]) begin
      if (tbl[k].do_reset) begin
        pulse_reset();
      end else begin
        for (int c = 0; c < tbl[k].n; c++) begin
          @(negedge clock);
          reset = 1'b1;
          set_req(tbl[k].req);
          chk($sformatf("seg%0d_cyc%0d", k, c), obs(), tbl[k].exp);
        end
      end
    end

    // Random stress with safety and service-latency checks.
    pulse_reset();
    veh_req = 4'b0000;
    g_prev  = 4'b0000;
    red_run = 2;
    for (int p = 0; p < 4; p++) begin
      waiting[p]  = 1'b0;
      wait_cnt[p] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clock);
      reset = 1'b1;
      g = {bus.turn_green, bus.down_green, bus.up_green, bus.pedestrian_green};
      y = {bus.turn_yellow, bus.down_yellow, bus.up_yellow, bus.pedestrian_flash};

      chk("conflict", 12'((g[0] && (g[1] || g[2] || g[3])) || (g[3] && (g[1] || g[2]))), 12'h0);
      chk("green_and_yellow", 12'(g & y), 12'h0);
      chk("green_to_yellow", 12'(g_prev & ~g & ~y), 12'h0);
      if ((g & ~g_prev) != 4'b0000 && g_prev == 4'b0000)
        chk("clearance", 12'(red_run >= 2), 12'h1);
      chk("active_mask", bus.active_phase, 4'(g | y));

      for (int p = 1; p < 4; p++)
        if ($urandom_range(0, 9) == 0) veh_req[p] = ~veh_req[p];
      r    = veh_req;
      r[0] = ($urandom_range(0, 19) == 0);
      set_req(r);

      starve = 1'b0;
      for (int p = 0; p < 4; p++) begin
        if (g[p]) begin
          waiting[p]  = 1'b0;
          wait_cnt[p] = 0;
        end else if (waiting[p] || r[p]) begin
          waiting[p]  = 1'b1;
          wait_cnt[p] = wait_cnt[p] + 1;
          if (wait_cnt[p] > 200) begin
            starve      = 1'b1;
            waiting[p]  = 1'b0;
            wait_cnt[p] = 0;
          end
        end
      end
      chk("service_latency", 12'(starve), 12'h0);

      red_run = ((g | y) == 4'b0000) ? red_run + 1 : 0;
      g_prev  = g;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
